// File: rtl/pixel_hit_detector_pkg.sv
// Shared duck-hunt screen geometry, colours, FSM encoding and pixel address helper.
// Pure declarations: no latency, no flow control.
package pixel_hit_detector_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;
   localparam int ADDR_W   = 15;
   localparam int FB_DEPTH = SCREEN_W * SCREEN_H;

   localparam logic [ADDR_W-1:0] FB_LAST = 15'd19199;

   typedef logic [COLOUR_W-1:0] colour_t;

   localparam colour_t BG_COLOUR     = 3'b000;
   localparam colour_t DUCK_COLOUR   = 3'b110;
   localparam colour_t SKY_COLOUR    = 3'b011;
   localparam colour_t TARGET_COLOUR = DUCK_COLOUR;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } fsm_state_t;

   // y*160 + x built from shifts so no multiplier is needed
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

   function automatic logic in_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
   endfunction

endpackage

// File: rtl/pixel_hit_detector_if.sv
// Plot-snoop, shot request and hit result signals between the game logic and the detector.
// Shot request is valid/ready; result is a one-cycle valid pulse with no backpressure.
interface pixel_hit_detector_if;
   import pixel_hit_detector_pkg::*;

   logic             plot;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   colour_t          colour;
   logic             shot_valid;
   logic [X_W-1:0]   shot_x;
   logic [Y_W-1:0]   shot_y;
   logic             shot_ready;
   logic             result_valid;
   logic             hit;
   colour_t          hit_colour;
   logic [3:0]       hit_count;
   logic             busy;

   modport master (
      output plot, x, y, colour, shot_valid, shot_x, shot_y,
      input  shot_ready, result_valid, hit, hit_colour, hit_count, busy
   );

   modport slave (
      input  plot, x, y, colour, shot_valid, shot_x, shot_y,
      output shot_ready, result_valid, hit, hit_colour, hit_count, busy
   );

endinterface

// File: rtl/pixel_hit_detector_fb_shadow_ram.sv
// 19200 x 3 simple dual-port shadow framebuffer; 1-cycle synchronous read, old data on collision.
// No flow control: one write and one read may be issued every cycle.
module pixel_hit_detector_fb_shadow_ram
   import pixel_hit_detector_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  colour_t           wdat,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output colour_t           rdat
);

   colour_t mem [FB_DEPTH];

   // Both ports in one process: the read sees the pre-edge contents (read-before-write)
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdat;
      end
      if (re) begin
         rdat <= mem[raddr];
      end
   end

endmodule

// File: rtl/pixel_hit_detector.sv
// Shadows VGA plot writes and answers crosshair shots; result_valid 2 cycles after shot accept.
// shot_ready only in IDLE, so shots are held off during CLEAR and while a shot is in flight.
module pixel_hit_detector
   import pixel_hit_detector_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   pixel_hit_detector_if.slave bus
);

   fsm_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q;
   logic              shot_acc;
   logic              shot_oor_q;
   logic              hit_q;
   colour_t           hit_colour_q;
   logic [3:0]        hit_count_q;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   colour_t           ram_wdat;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_raddr;
   colour_t           ram_rdat;

   logic              sample_hit;
   colour_t           sample_colour;

   always_comb begin
      state_d          = state_q;
      shot_acc         = 1'b0;
      bus.shot_ready   = 1'b0;
      bus.result_valid = 1'b0;
      bus.busy         = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            bus.busy = 1'b1;
            if (clr_addr_q == FB_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            bus.shot_ready = 1'b1;
            if (bus.shot_valid) begin
               shot_acc = 1'b1;
               state_d  = ST_READ;
            end
         end
         ST_READ: state_d = ST_RESP;
         ST_RESP: begin
            bus.result_valid = 1'b1;
            state_d          = ST_IDLE;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   // Clear sweep owns the write port; snooped plots are dropped until it finishes
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = clr_addr_q;
      ram_wdat  = BG_COLOUR;
      if (state_q == ST_CLEAR) begin
         ram_we = 1'b1;
      end else if (bus.plot && in_screen(bus.x, bus.y)) begin
         ram_we    = 1'b1;
         ram_waddr = pixel_addr(bus.x, bus.y);
         ram_wdat  = bus.colour;
      end
   end

   assign ram_re    = shot_acc && in_screen(bus.shot_x, bus.shot_y);
   assign ram_raddr = pixel_addr(bus.shot_x, bus.shot_y);

   assign sample_hit    = !shot_oor_q && (ram_rdat == TARGET_COLOUR);
   assign sample_colour = shot_oor_q ? BG_COLOUR : ram_rdat;

   pixel_hit_detector_fb_shadow_ram u_fb_shadow_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdat  (ram_wdat),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdat  (ram_rdat)
   );

   // Result registers load on the READ->RESP edge so they are valid alongside result_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         clr_addr_q   <= '0;
         shot_oor_q   <= 1'b0;
         hit_q        <= 1'b0;
         hit_colour_q <= BG_COLOUR;
         hit_count_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_CLEAR) clr_addr_q <= clr_addr_q + 15'd1;
         if (shot_acc) shot_oor_q <= !in_screen(bus.shot_x, bus.shot_y);
         if (state_q == ST_READ) begin
            hit_q        <= sample_hit;
            hit_colour_q <= sample_colour;
            if (sample_hit && hit_count_q != 4'd15) hit_count_q <= hit_count_q + 4'd1;
         end
      end
   end

   assign bus.hit        = hit_q;
   assign bus.hit_colour = hit_colour_q;
   assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_pixel_hit_detector.sv
// Directed bench for pixel_hit_detector: clear timing, hit/miss, edges, collision, saturation, reset.
module tb_pixel_hit_detector;

   logic clk;
   logic reset;

   pixel_hit_detector_if bus ();

   pixel_hit_detector dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks;
   int         errors;
   int         lat;
   int         clr_cycles;
   logic       r_vld;
   logic       r_hit;
   logic [2:0] r_col;
   logic [3:0] r_cnt;
   logic       seen_vld;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      bus.plot   = 1'b1;
      bus.x      = px;
      bus.y      = py;
      bus.colour = pc;
      tick();
      bus.plot   = 1'b0;
   endtask

   // Holds the request until ready, then measures cycles from the accept edge to result_valid
   task automatic shot(input logic [7:0] sx, input logic [6:0] sy);
      int n;
      bus.shot_valid = 1'b1;
      bus.shot_x     = sx;
      bus.shot_y     = sy;
      n = 0;
      while (!bus.shot_ready && n < 50) begin
         tick();
         n++;
      end
      check("shot_ready_wait", 32'(n < 50), 32'd1);
      tick();
      bus.shot_valid = 1'b0;
      bus.plot       = 1'b0;
      lat = 1;
      while (!bus.result_valid && lat < 10) begin
         tick();
         lat++;
      end
      r_vld = bus.result_valid;
      r_hit = bus.hit;
      r_col = bus.hit_colour;
      r_cnt = bus.hit_count;
   endtask

   task automatic wait_clear(output int cnt);
      cnt = 0;
      while (bus.busy && cnt < 20000) begin
         if (cnt == 18000) begin
            bus.plot   = 1'b1;
            bus.x      = 8'd0;
            bus.y      = 7'd0;
            bus.colour = 3'b110;
         end
         if (cnt == 19100) bus.plot = 1'b0;
         if (bus.result_valid) seen_vld = 1'b1;
         tick();
         cnt++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      seen_vld = 1'b0;
      reset = 1'b1;
      bus.plot = 1'b0;
      bus.x = '0;
      bus.y = '0;
      bus.colour = '0;
      bus.shot_valid = 1'b0;
      bus.shot_x = '0;
      bus.shot_y = '0;

      // 1: reset values, clear duration, plot during clear dropped, first shot
      tick();
      reset = 1'b0;
      check("rst_busy", 32'(bus.busy), 32'd1);
      check("rst_ready", 32'(bus.shot_ready), 32'd0);
      check("rst_rvalid", 32'(bus.result_valid), 32'd0);
      check("rst_hit", 32'(bus.hit), 32'd0);
      check("rst_colour", 32'(bus.hit_colour), 32'd0);
      check("rst_count", 32'(bus.hit_count), 32'd0);
      wait_clear(clr_cycles);
      check("clear_cycles", 32'(clr_cycles), 32'd19200);
      check("ready_after_clear", 32'(bus.shot_ready), 32'd1);
      check("busy_after_clear", 32'(bus.busy), 32'd0);
      shot(8'd0, 7'd0);
      check("t1_latency", 32'(lat), 32'd2);
      check("t1_colour", 32'(r_col), 32'd0);
      check("t1_hit", 32'(r_hit), 32'd0);

      // 2: plain hit, latency and one-cycle pulse
      plot_px(8'd10, 7'd20, 3'b110);
      shot(8'd10, 7'd20);
      check("t2_latency", 32'(lat), 32'd2);
      check("t2_hit", 32'(r_hit), 32'd1);
      check("t2_colour", 32'(r_col), 32'd6);
      check("t2_count", 32'(r_cnt), 32'd1);
      tick();
      check("t2_pulse", 32'(bus.result_valid), 32'd0);
      check("t2_hold_hit", 32'(bus.hit), 32'd1);

      // 3: screen corner, out-of-range plot/shot, non-target colour
      plot_px(8'd159, 7'd119, 3'b110);
      plot_px(8'd160, 7'd5, 3'b110);
      plot_px(8'd50, 7'd60, 3'b011);
      shot(8'd159, 7'd119);
      check("t3_corner_hit", 32'(r_hit), 32'd1);
      check("t3_corner_count", 32'(r_cnt), 32'd2);
      shot(8'd160, 7'd5);
      check("t3_oor_latency", 32'(lat), 32'd2);
      check("t3_oor_valid", 32'(r_vld), 32'd1);
      check("t3_oor_hit", 32'(r_hit), 32'd0);
      check("t3_oor_colour", 32'(r_col), 32'd0);
      shot(8'd50, 7'd60);
      check("t3_sky_hit", 32'(r_hit), 32'd0);
      check("t3_sky_colour", 32'(r_col), 32'd3);
      check("t3_sky_count", 32'(r_cnt), 32'd2);

      // 4: plot and shot to the same pixel on the accept edge returns the old colour
      tick();
      check("t4_ready", 32'(bus.shot_ready), 32'd1);
      bus.plot   = 1'b1;
      bus.x      = 8'd30;
      bus.y      = 7'd30;
      bus.colour = 3'b110;
      shot(8'd30, 7'd30);
      check("t4_rbw_hit", 32'(r_hit), 32'd0);
      check("t4_rbw_colour", 32'(r_col), 32'd0);
      shot(8'd30, 7'd30);
      check("t4_repeat_hit", 32'(r_hit), 32'd1);
      check("t4_repeat_count", 32'(r_cnt), 32'd3);

      // 5: counter saturates at 15
      for (int i = 1; i <= 17; i++) begin
         shot(8'd10, 7'd20);
         check($sformatf("t5_count_%0d", i), 32'(r_cnt), (3 + i > 15) ? 32'd15 : 32'(3 + i));
      end

      // 6: reset while in READ discards the pending result and clears the framebuffer
      tick();
      bus.shot_valid = 1'b1;
      bus.shot_x     = 8'd10;
      bus.shot_y     = 7'd20;
      check("t6_ready", 32'(bus.shot_ready), 32'd1);
      tick();
      bus.shot_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rvalid", 32'(bus.result_valid), 32'd0);
      check("t6_count", 32'(bus.hit_count), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd1);
      check("t6_hit", 32'(bus.hit), 32'd0);
      wait_clear(clr_cycles);
      check("t6_clear_cycles", 32'(clr_cycles), 32'd19200);
      check("t6_no_result", 32'(seen_vld), 32'd0);
      shot(8'd10, 7'd20);
      check("t6_cleared_colour", 32'(r_col), 32'd0);
      check("t6_cleared_hit", 32'(r_hit), 32'd0);
      shot(8'd159, 7'd119);
      check("t6_corner_colour", 32'(r_col), 32'd0);
      check("t6_final_count", 32'(r_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
